// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
//   Sequencer for the DDS/NCO phase-accumulator counter. Preloads the counter
//   phase, then walks the counter increment from a start value to a stop value
//   (up or down by one per step), holding each increment for a dwell count.
//   All outputs are registered.
//
//   Optional feature macro: SWEEP_PAUSE_EN
//     defined   : adds input 'pause'. While high in RUN, the counter is disabled
//                 and the sweep position (dwell count, incr, step index) is frozen.
//     undefined : no 'pause' port; behaves as if pause were tied low.
module nco_sweep_ctrl #(
   parameter int ADDR_WIDTH  = 10,
   parameter int INCR_WIDTH  = 4,
   parameter int DWELL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
`ifdef SWEEP_PAUSE_EN
   input  logic                   pause,
`endif
   input  logic [ADDR_WIDTH-1:0]  cfg_phase,
   input  logic [INCR_WIDTH-1:0]  cfg_start,
   input  logic [INCR_WIDTH-1:0]  cfg_stop,
   input  logic [DWELL_WIDTH-1:0] cfg_dwell,
   input  logic                   cfg_updn,
   output logic                   ctr_enable,
   output logic                   ctr_updn,
   output logic                   ctr_preload,
   output logic [ADDR_WIDTH-1:0]  ctr_pl_data,
   output logic [INCR_WIDTH-1:0]  ctr_incr,
   output logic                   busy,
   output logic                   done,
   output logic [INCR_WIDTH-1:0]  step_idx
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                 state, state_nxt;
   logic [DWELL_WIDTH-1:0] dwell_cnt, dwell_cnt_nxt;

   // Sweep shadows. Phase, start incr and direction need no separate shadow:
   // they are captured straight into ctr_pl_data / ctr_incr / ctr_updn, which
   // hold their value for the whole sweep.
   logic [INCR_WIDTH-1:0]  sh_stop, sh_stop_nxt;
   logic [DWELL_WIDTH-1:0] sh_dwell_last, sh_dwell_last_nxt;
   logic                   sh_step_up, sh_step_up_nxt;

   logic                   enable_nxt, updn_nxt, preload_nxt, busy_nxt, done_nxt;
   logic [ADDR_WIDTH-1:0]  pl_data_nxt;
   logic [INCR_WIDTH-1:0]  incr_nxt, step_idx_nxt;
   logic                   pause_act;

`ifdef SWEEP_PAUSE_EN
   assign pause_act = pause;
`else
   assign pause_act = 1'b0;
`endif

   // Next-state and next-output decode; outputs are registered below so each
   // state's output values are produced on the edge that enters that state.
   always_comb begin
      // NOTE: every signal gets a default before the case; a path that leaves
      // one unassigned would infer a latch.
      state_nxt         = state;
      dwell_cnt_nxt     = dwell_cnt;
      sh_stop_nxt       = sh_stop;
      sh_dwell_last_nxt = sh_dwell_last;
      sh_step_up_nxt    = sh_step_up;
      enable_nxt        = 1'b0;
      preload_nxt       = 1'b0;
      busy_nxt          = 1'b0;
      done_nxt          = 1'b0;
      updn_nxt          = ctr_updn;
      pl_data_nxt       = ctr_pl_data;
      incr_nxt          = ctr_incr;
      step_idx_nxt      = step_idx;

      if (abort) begin
         // Stop at once: counter disabled, no done pulse, incr left as is.
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state_nxt         = ST_LOAD;
                  sh_stop_nxt       = cfg_stop;
                  sh_step_up_nxt    = (cfg_stop > cfg_start);
                  // A zero dwell is stretched to one cycle per step.
                  sh_dwell_last_nxt = (cfg_dwell == '0) ? '0
                                                         : cfg_dwell - DWELL_WIDTH'(1);
                  preload_nxt       = 1'b1;
                  enable_nxt        = 1'b1;
                  busy_nxt          = 1'b1;
                  pl_data_nxt       = cfg_phase;
                  incr_nxt          = cfg_start;
                  updn_nxt          = cfg_updn;
                  dwell_cnt_nxt     = '0;
                  step_idx_nxt      = '0;
               end
            end
            ST_LOAD: begin
               state_nxt     = ST_RUN;
               enable_nxt    = 1'b1;
               busy_nxt      = 1'b1;
               dwell_cnt_nxt = '0;
               step_idx_nxt  = '0;
            end
            ST_RUN: begin
               busy_nxt = 1'b1;
               if (pause_act) begin
                  // Frozen: counter disabled, sweep position untouched.
                  enable_nxt = 1'b0;
               end else if (dwell_cnt == sh_dwell_last) begin
                  if (ctr_incr == sh_stop) begin
                     state_nxt = ST_DONE;
                     busy_nxt  = 1'b0;
                     done_nxt  = 1'b1;
                  end else begin
                     // Never wraps: stepping always lands on sh_stop.
                     enable_nxt    = 1'b1;
                     incr_nxt      = sh_step_up ? ctr_incr + INCR_WIDTH'(1)
                                                : ctr_incr - INCR_WIDTH'(1);
                     dwell_cnt_nxt = '0;
                     step_idx_nxt  = step_idx + INCR_WIDTH'(1);
                  end
               end else begin
                  enable_nxt    = 1'b1;
                  dwell_cnt_nxt = dwell_cnt + DWELL_WIDTH'(1);
               end
            end
            ST_DONE: begin
               state_nxt = ST_IDLE;
            end
            default: begin
               state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // State, sweep shadows and registered outputs; reset clears everything.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= ST_IDLE;
         dwell_cnt     <= '0;
         sh_stop       <= '0;
         sh_dwell_last <= '0;
         sh_step_up    <= 1'b0;
         ctr_enable    <= 1'b0;
         ctr_updn      <= 1'b0;
         ctr_preload   <= 1'b0;
         ctr_pl_data   <= '0;
         ctr_incr      <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         step_idx      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state         <= state_nxt;
         dwell_cnt     <= dwell_cnt_nxt;
         sh_stop       <= sh_stop_nxt;
         sh_dwell_last <= sh_dwell_last_nxt;
         sh_step_up    <= sh_step_up_nxt;
         ctr_enable    <= enable_nxt;
         ctr_updn      <= updn_nxt;
         ctr_preload   <= preload_nxt;
         ctr_pl_data   <= pl_data_nxt;
         ctr_incr      <= incr_nxt;
         busy          <= busy_nxt;
         done          <= done_nxt;
         step_idx      <= step_idx_nxt;
      end
   end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl
//   Directed self-checking bench for nco_sweep_ctrl: up, down and degenerate
//   sweeps, ignored start, abort, start/abort collision, asynchronous reset,
//   and (when SWEEP_PAUSE_EN is defined) pause.
module tb_nco_sweep_ctrl;

   localparam int ADDR_WIDTH  = 10;
   localparam int INCR_WIDTH  = 4;
   localparam int DWELL_WIDTH = 16;

   logic                   clk;
   logic                   reset;
   logic                   start;
   logic                   abort;
   logic                   pause;
   logic [ADDR_WIDTH-1:0]  cfg_phase;
   logic [INCR_WIDTH-1:0]  cfg_start;
   logic [INCR_WIDTH-1:0]  cfg_stop;
   logic [DWELL_WIDTH-1:0] cfg_dwell;
   logic                   cfg_updn;
   logic                   ctr_enable;
   logic                   ctr_updn;
   logic                   ctr_preload;
   logic [ADDR_WIDTH-1:0]  ctr_pl_data;
   logic [INCR_WIDTH-1:0]  ctr_incr;
   logic                   busy;
   logic                   done;
   logic [INCR_WIDTH-1:0]  step_idx;

   int checks = 0;
   int errors = 0;

   nco_sweep_ctrl #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INCR_WIDTH (INCR_WIDTH),
      .DWELL_WIDTH(DWELL_WIDTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
`ifdef SWEEP_PAUSE_EN
      .pause      (pause),
`endif
      .cfg_phase  (cfg_phase),
      .cfg_start  (cfg_start),
      .cfg_stop   (cfg_stop),
      .cfg_dwell  (cfg_dwell),
      .cfg_updn   (cfg_updn),
      .ctr_enable (ctr_enable),
      .ctr_updn   (ctr_updn),
      .ctr_preload(ctr_preload),
      .ctr_pl_data(ctr_pl_data),
      .ctr_incr   (ctr_incr),
      .busy       (busy),
      .done       (done),
      .step_idx   (step_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then stable for the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctl(input string tag, input bit en, input bit pre,
                            input bit bsy, input bit dn);
      check({tag, " enable"},  ctr_enable,  en);
      check({tag, " preload"}, ctr_preload, pre);
      check({tag, " busy"},    busy,        bsy);
      check({tag, " done"},    done,        dn);
   endtask

   // Full sweep with cfg scrambled after start (shadowing), per-cycle checks,
   // enable-cycle count against a hand-computed total, and a single done pulse.
   task automatic sweep_check(input string tag, input int phase, input int s, input int e,
                              input int dwell, input bit updn, input int exp_en,
                              input bit start_in_done);
      int d, n, dir, en_cnt;
      d   = (dwell == 0) ? 1 : dwell;
      n   = (e >= s) ? (e - s + 1) : (s - e + 1);
      dir = (e >= s) ? 1 : -1;
      cfg_phase = ADDR_WIDTH'(phase);
      cfg_start = INCR_WIDTH'(s);
      cfg_stop  = INCR_WIDTH'(e);
      cfg_dwell = DWELL_WIDTH'(dwell);
      cfg_updn  = updn;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      cfg_phase = ~cfg_phase;
      cfg_start = cfg_start + 4'd3;
      cfg_stop  = ~cfg_stop;
      cfg_dwell = 16'd7;
      cfg_updn  = ~updn;
      check_ctl({tag, " load"}, 1'b1, 1'b1, 1'b1, 1'b0);
      check({tag, " load pl_data"}, ctr_pl_data, phase);
      check({tag, " load incr"},    ctr_incr,    s);
      check({tag, " load updn"},    ctr_updn,    updn);
      check({tag, " load idx"},     step_idx,    0);
      en_cnt = 0;
      for (int k = 0; k < d * n; k++) begin
         tick();
         check_ctl($sformatf("%s run%0d", tag, k), 1'b1, 1'b0, 1'b1, 1'b0);
         check($sformatf("%s run%0d incr", tag, k), ctr_incr, s + dir * (k / d));
         check($sformatf("%s run%0d idx", tag, k),  step_idx, k / d);
         check($sformatf("%s run%0d updn", tag, k), ctr_updn, updn);
         if (ctr_enable) en_cnt++;
      end
      check({tag, " enable cycles"}, en_cnt, exp_en);
      tick();
      check_ctl({tag, " done"}, 1'b0, 1'b0, 1'b0, 1'b1);
      check({tag, " done incr"}, ctr_incr, e);
      if (start_in_done) start = 1'b1;
      tick();
      start = 1'b0;
      check_ctl({tag, " after done"}, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_ctl({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset     = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      pause     = 1'b0;
      cfg_phase = '0;
      cfg_start = '0;
      cfg_stop  = '0;
      cfg_dwell = '0;
      cfg_updn  = 1'b0;

      // Reset state
      #12;
      check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset incr", ctr_incr, 0);
      check("reset idx",  step_idx, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      check_ctl("idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // 1. Up sweep 1..3, dwell 4, phase 5
      sweep_check("s1", 5, 1, 3, 4, 1'b0, 12, 1'b0);

      // 2. Down sweep 6..2, dwell 2; a start during DONE is ignored
      sweep_check("s2", 9, 6, 2, 2, 1'b1, 10, 1'b1);

      // 3. Degenerate sweep, start==stop, dwell 0 acts as 1
      sweep_check("s3", 1023, 4, 4, 0, 1'b0, 1, 1'b0);

      // 4. Start ignored while busy, then abort on the 3rd RUN cycle
      cfg_phase = 10'd5; cfg_start = 4'd1; cfg_stop = 4'd3; cfg_dwell = 16'd4; cfg_updn = 1'b0;
      start = 1'b1;
      tick();                                   // LOAD
      start = 1'b0;
      tick();                                   // RUN 1
      start = 1'b1;
      tick();                                   // RUN 2, start ignored
      start = 1'b0;
      check_ctl("s4 run2", 1'b1, 1'b0, 1'b1, 1'b0);
      check("s4 run2 incr", ctr_incr, 1);
      tick();                                   // RUN 3
      check_ctl("s4 run3", 1'b1, 1'b0, 1'b1, 1'b0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_ctl("s4 aborted", 1'b0, 1'b0, 1'b0, 1'b0);
      check("s4 aborted incr", ctr_incr, 1);
      for (int k = 0; k < 4; k++) begin
         tick();
         check_ctl($sformatf("s4 post%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // start and abort together in IDLE: abort wins
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check_ctl("s4 start+abort", 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check_ctl("s4 start+abort idle", 1'b0, 1'b0, 1'b0, 1'b0);

      // 5. Asynchronous reset mid-RUN, not aligned to clk
      cfg_phase = 10'd5; cfg_start = 4'd1; cfg_stop = 4'd3; cfg_dwell = 16'd4; cfg_updn = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      check("s5 pre-reset busy", busy, 1);
      #3;
      reset = 1'b0;
      #2;
      check_ctl("s5 async reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check("s5 async pl_data", ctr_pl_data, 0);
      check("s5 async incr",    ctr_incr,    0);
      check("s5 async updn",    ctr_updn,    0);
      check("s5 async idx",     step_idx,    0);
      tick();
      #2;
      reset = 1'b1;
      tick();
      check_ctl("s5 idle", 1'b0, 1'b0, 1'b0, 1'b0);
      sweep_check("s5 rerun", 5, 1, 3, 4, 1'b0, 12, 1'b0);

`ifdef SWEEP_PAUSE_EN
      // 6. Pause held 5 edges during step 2 of scenario 1
      begin
         int en_cnt, cyc, low_cnt;
         cfg_phase = 10'd5; cfg_start = 4'd1; cfg_stop = 4'd3; cfg_dwell = 16'd4; cfg_updn = 1'b0;
         start = 1'b1;
         tick();                                // LOAD
         start = 1'b0;
         en_cnt  = 0;
         low_cnt = 0;
         cyc     = 0;
         while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 6) pause = 1'b1;         // 2nd cycle of incr=2
            if (cyc == 11) pause = 1'b0;
            if (busy && ctr_enable) en_cnt++;
            if (busy && !ctr_enable) begin
               low_cnt++;
               check($sformatf("s6 paused incr c%0d", cyc), ctr_incr, 2);
            end
         end
         check("s6 done seen", done, 1);
         check("s6 cycles to done", cyc, 18);
         check("s6 enable cycles", en_cnt, 12);
         check("s6 paused cycles", low_cnt, 5);
         tick();
         check_ctl("s6 idle", 1'b0, 1'b0, 1'b0, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
